vend_ctrl_param: RTL and testbench



---
 rtl/vend_ctrl_param.sv | 167 ++++++++++++++++
 tb/tb_vend_ctrl_param.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_ctrl_param.sv
// Vending controller: coin credit, one-hot selection latch, vend and greedy change handshakes.
// Define AUTO_CANCEL_EN to refund automatically after TIMEOUT_CYC quiet cycles in COLLECT.
//
// state   | meaning
// IDLE    | no credit, waiting for a coin
// COLLECT | credit > 0, coins/selection/buy/cancel accepted
// VEND    | vend_valid held until vend_ready
// CHANGE  | chg_valid held per coin until chg_ready
module vend_ctrl_param #(
  parameter int N_PROD = 8,
  parameter int CREDIT_W = 12,
  parameter int MAX_CREDIT = 1000,
  parameter logic [N_PROD*CREDIT_W-1:0] PRICE_TABLE =
    {12'd575, 12'd400, 12'd450, 12'd350, 12'd350, 12'd300, 12'd200, 12'd100},
  parameter int TIMEOUT_CYC = 50_000_000,
  localparam int IDX_W = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  input  logic [N_PROD-1:0]   sel,
  input  logic                buy,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic [N_PROD-1:0]   sel_led,
  output logic                vend_valid,
  output logic [IDX_W-1:0]    vend_idx,
  input  logic                vend_ready,
  output logic                chg_valid,
  output logic [1:0]          chg_coin,
  input  logic                chg_ready,
  output logic                coin_rej,
  output logic                err_funds,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

  localparam logic [CREDIT_W:0]   MAX_SUM = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] C25  = CREDIT_W'(25);
  localparam logic [CREDIT_W-1:0] C50  = CREDIT_W'(50);
  localparam logic [CREDIT_W-1:0] C100 = CREDIT_W'(100);

  state_t state, state_nx;

  logic [CREDIT_W-1:0] coin_amt, price, chg_amt, vend_rem, chg_rem;
  logic [CREDIT_W:0]   coin_sum;
  logic [IDX_W-1:0]    sel_idx;
  logic collecting, coin_ok, can_buy, do_buy, do_cancel, buy_err;
  logic vend_hs, chg_hs, sel_hot, timeout;

  always_comb begin
    case (coin_type)
      2'b00:   coin_amt = C25;
      2'b01:   coin_amt = C50;
      2'b10:   coin_amt = C100;
      default: coin_amt = '0;
    endcase
  end

  always_comb begin
    sel_idx = '0;
    for (int k = 0; k < N_PROD; k++) begin
      if (sel[k]) sel_idx = IDX_W'(k);
    end
  end

  assign sel_hot    = ($countones(sel) == 1);
  assign collecting = (state == IDLE) || (state == COLLECT);
  assign coin_sum   = {1'b0, credit} + {1'b0, coin_amt};
  // A coin arriving together with buy/cancel is refused so the purchase decision sees stable credit.
  assign coin_ok    = coin_valid && collecting && (coin_type != 2'b11) &&
                      (coin_sum <= MAX_SUM) && !buy && !cancel;

  assign price      = PRICE_TABLE[int'(vend_idx)*CREDIT_W +: CREDIT_W];
  assign can_buy    = (sel_led != '0) && (credit >= price);
  assign do_cancel  = (state == COLLECT) && (cancel || timeout);
  assign do_buy     = (state == COLLECT) && buy && !cancel && can_buy;
  assign buy_err    = buy && !cancel && ((state == IDLE) || ((state == COLLECT) && !can_buy));

  assign vend_hs    = (state == VEND) && vend_ready;
  assign chg_hs     = (state == CHANGE) && chg_ready;
  assign chg_amt    = (credit >= C100) ? C100 : (credit >= C50) ? C50 : C25;
  assign vend_rem   = credit - price;
  assign chg_rem    = credit - chg_amt;

`ifdef AUTO_CANCEL_EN
  localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0]   to_cnt;
  logic [N_PROD-1:0] sel_q;
  logic              quiet;

  assign quiet = !(coin_valid || buy || cancel || (sel != sel_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= TO_LOAD;
      sel_q  <= '0;
    end else begin
      sel_q <= sel;
      if ((state != COLLECT) || !quiet) to_cnt <= TO_LOAD;
      else if (to_cnt != '0)            to_cnt <= to_cnt - 1'b1;
    end
  end

  assign timeout = (state == COLLECT) && quiet && (to_cnt == '0);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (coin_ok) state_nx = COLLECT;
      COLLECT: begin
        if (do_cancel)   state_nx = CHANGE;
        else if (do_buy) state_nx = VEND;
      end
      VEND:    if (vend_hs) state_nx = (vend_rem >= C25) ? CHANGE : IDLE;
      CHANGE:  if (chg_hs && (chg_rem < C25)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    vend_valid = (state == VEND);
    chg_valid  = (state == CHANGE);
    busy       = (state == VEND) || (state == CHANGE);
    if (credit >= C100)     chg_coin = 2'b10;
    else if (credit >= C50) chg_coin = 2'b01;
    else                    chg_coin = 2'b00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit    <= '0;
      sel_led   <= '0;
      vend_idx  <= '0;
      coin_rej  <= 1'b0;
      err_funds <= 1'b0;
    end else begin
      coin_rej  <= coin_valid && !coin_ok;
      err_funds <= buy_err;

      // Residue below the smallest coin is forfeited on the way back to IDLE.
      if (coin_ok)      credit <= coin_sum[CREDIT_W-1:0];
      else if (vend_hs) credit <= (vend_rem >= C25) ? vend_rem : '0;
      else if (chg_hs)  credit <= (chg_rem >= C25) ? chg_rem : '0;

      if (do_cancel || vend_hs) begin
        sel_led <= '0;
      end else if (collecting && sel_hot && !do_buy) begin
        sel_led  <= sel;
        vend_idx <= sel_idx;
      end
    end
  end

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Self-checking bench for vend_ctrl_param: directed scenarios plus randomized purchases
// checked against a transaction-level model of credit, price and greedy change.
module tb_vend_ctrl_param;
  localparam int N_PROD = 8;
  localparam int CREDIT_W = 12;
`ifdef AUTO_CANCEL_EN
  localparam int TB_TO = 16;
`else
  localparam int TB_TO = 50_000_000;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic coin_valid = 1'b0, buy = 1'b0, cancel = 1'b0, vend_ready = 1'b0, chg_ready = 1'b0;
  logic [1:0] coin_type = 2'b00;
  logic [N_PROD-1:0] sel = '0;
  logic [CREDIT_W-1:0] credit;
  logic [N_PROD-1:0] sel_led;
  logic vend_valid, chg_valid, coin_rej, err_funds, busy;
  logic [2:0] vend_idx;
  logic [1:0] chg_coin;

  int checks = 0;
  int errors = 0;
  int price_tab[8] = '{100, 200, 300, 350, 350, 450, 400, 575};

  logic [1:0] exp_q[$];
  logic [1:0] got_q[$];
  bit chg_timeout, chg_unstable;
  int chg_span;

  always #5 clk = ~clk;

  vend_ctrl_param #(.TIMEOUT_CYC(TB_TO)) dut (
    .clk(clk), .rst_n(rst_n), .coin_valid(coin_valid), .coin_type(coin_type), .sel(sel),
    .buy(buy), .cancel(cancel), .credit(credit), .sel_led(sel_led), .vend_valid(vend_valid),
    .vend_idx(vend_idx), .vend_ready(vend_ready), .chg_valid(chg_valid), .chg_coin(chg_coin),
    .chg_ready(chg_ready), .coin_rej(coin_rej), .err_funds(err_funds), .busy(busy)
  );

  function automatic int coin_cents(input int t);
    case (t)
      0: return 25;
      1: return 50;
      2: return 100;
      default: return 0;
    endcase
  endfunction

  function automatic void make_change(input int amt);
    exp_q.delete();
    repeat (amt / 100) exp_q.push_back(2'b10);
    amt = amt % 100;
    repeat (amt / 50) exp_q.push_back(2'b01);
    amt = amt % 50;
    repeat (amt / 25) exp_q.push_back(2'b00);
  endfunction

  function automatic bit same_seq();
    if (got_q.size() != exp_q.size()) return 1'b0;
    foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic do_reset();
    coin_valid = 0; buy = 0; cancel = 0; vend_ready = 0; chg_ready = 0; sel = '0; coin_type = 0;
    rst_n = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic drive_coin(input logic [1:0] t, output logic rej);
    @(negedge clk); coin_valid = 1; coin_type = t;
    @(negedge clk); coin_valid = 0; rej = coin_rej;
  endtask

  task automatic pulse_cancel();
    @(negedge clk); cancel = 1;
    @(negedge clk); cancel = 0;
  endtask

  task automatic run_change(input bit always_rdy);
    int cyc, first, last;
    bit pend, r;
    logic [1:0] pc;
    got_q.delete(); chg_timeout = 0; chg_unstable = 0; cyc = 0; pend = 0; pc = 0;
    first = -1; last = -1;
    while (!chg_valid && cyc < 50) begin @(negedge clk); cyc++; end
    if (!chg_valid) begin chg_timeout = 1; chg_span = -1; return; end
    cyc = 0;
    while (chg_valid && cyc < 400) begin
      if (pend && chg_coin !== pc) chg_unstable = 1;
      r = always_rdy ? 1'b1 : 1'($urandom_range(0, 1));
      chg_ready = r;
      if (r) begin
        got_q.push_back(chg_coin); pend = 0;
        if (first < 0) first = cyc;
        last = cyc;
      end else begin
        pend = 1; pc = chg_coin;
      end
      @(negedge clk); cyc++;
    end
    chg_ready = 0;
    if (chg_valid) chg_timeout = 1;
    chg_span = last - first;
  endtask

  task automatic test_reset();
    rst_n = 0;
    @(negedge clk);
    checks++; if (credit !== 0) begin errors++; $display("FAIL reset_credit: got %0d need 0", credit); end
    checks++; if ({sel_led, vend_idx} !== '0) begin errors++; $display("FAIL reset_sel: sel_led %b idx %0d need 0", sel_led, vend_idx); end
    checks++; if ({vend_valid, chg_valid, chg_coin, coin_rej, err_funds, busy} !== '0) begin
      errors++; $display("FAIL reset_flags: vv %b cv %b coin %b rej %b err %b busy %b need 0", vend_valid, chg_valid, chg_coin, coin_rej, err_funds, busy);
    end
    do_reset();
  endtask

  task automatic test_purchase();
    logic r; int held;
    do_reset();
    drive_coin(2'b10, r); drive_coin(2'b10, r); drive_coin(2'b01, r);
    checks++; if (credit !== 250) begin errors++; $display("FAIL buy_credit: got %0d need 250", credit); end
    sel = 8'b0000_0010;
    @(negedge clk);
    checks++; if (sel_led !== 8'b0000_0010 || vend_idx !== 3'd1) begin errors++; $display("FAIL buy_sel: sel_led %b idx %0d need 00000010 idx 1", sel_led, vend_idx); end
    sel = '0; buy = 1;
    @(negedge clk); buy = 0;
    held = 0;
    for (int i = 0; i < 3; i++) begin
      if (vend_valid === 1'b1 && vend_idx === 3'd1) held++;
      if (i == 2) vend_ready = 1;
      @(negedge clk);
    end
    vend_ready = 0;
    checks++; if (held !== 3) begin errors++; $display("FAIL vend_hold: held %0d need 3", held); end
    checks++; if (vend_valid !== 0 || sel_led !== 0) begin errors++; $display("FAIL vend_done: vv %b sel_led %b need 0 0", vend_valid, sel_led); end
    make_change(50);
    run_change(1'b0);
    checks++; if (!same_seq() || chg_timeout || chg_unstable) begin
      errors++; $display("FAIL vend_change: got %0d coins need %0d timeout %0d unstable %0d", got_q.size(), exp_q.size(), chg_timeout, chg_unstable);
    end
    checks++; if (credit !== 0 || busy !== 0) begin errors++; $display("FAIL vend_idle: credit %0d busy %b need 0 0", credit, busy); end
  endtask

  task automatic test_low_funds();
    logic r;
    do_reset();
    drive_coin(2'b00, r);
    @(negedge clk); sel = 8'b1000_0000;
    @(negedge clk); buy = 1;
    @(negedge clk); buy = 0;
    checks++; if (err_funds !== 1 || vend_valid !== 0) begin errors++; $display("FAIL low_err: err %b vv %b need 1 0", err_funds, vend_valid); end
    @(negedge clk);
    checks++; if (err_funds !== 0) begin errors++; $display("FAIL low_pulse: err %b need 0", err_funds); end
    checks++; if (credit !== 25 || busy !== 0) begin errors++; $display("FAIL low_state: credit %0d busy %b need 25 0", credit, busy); end
    sel = '0;
    pulse_cancel();
    make_change(25);
    run_change(1'b1);
    checks++; if (!same_seq() || chg_timeout) begin errors++; $display("FAIL low_refund: got %0d coins need %0d", got_q.size(), exp_q.size()); end
  endtask

  task automatic test_max_credit();
    logic r; int nrej;
    do_reset();
    nrej = 0;
    for (int i = 0; i < 10; i++) begin drive_coin(2'b10, r); if (r) nrej++; end
    checks++; if (nrej !== 0 || credit !== 1000) begin errors++; $display("FAIL max_fill: rej %0d credit %0d need 0 1000", nrej, credit); end
    drive_coin(2'b10, r);
    checks++; if (r !== 1 || credit !== 1000) begin errors++; $display("FAIL max_over: rej %b credit %0d need 1 1000", r, credit); end
    @(negedge clk);
    checks++; if (coin_rej !== 0) begin errors++; $display("FAIL max_pulse: rej %b need 0", coin_rej); end
    drive_coin(2'b11, r);
    checks++; if (r !== 1 || credit !== 1000) begin errors++; $display("FAIL invalid_coin: rej %b credit %0d need 1 1000", r, credit); end
    pulse_cancel();
    make_change(1000);
    run_change(1'b0);
    checks++; if (!same_seq() || chg_timeout || chg_unstable) begin errors++; $display("FAIL max_refund: got %0d coins need %0d", got_q.size(), exp_q.size()); end
  endtask

  task automatic test_cancel_refund();
    logic r;
    do_reset();
    drive_coin(2'b10, r); drive_coin(2'b01, r); drive_coin(2'b00, r);
    pulse_cancel();
    make_change(175);
    run_change(1'b1);
    checks++; if (!same_seq() || chg_timeout) begin
      errors++; $display("FAIL cancel_seq: got %0d coins (first %b) need 3 coins 10 01 00", got_q.size(), (got_q.size() > 0) ? got_q[0] : 2'bxx);
    end
    checks++; if (chg_span !== 2) begin errors++; $display("FAIL cancel_rate: span %0d need 2", chg_span); end
    checks++; if (credit !== 0 || sel_led !== 0) begin errors++; $display("FAIL cancel_end: credit %0d sel_led %b need 0 0", credit, sel_led); end
  endtask

  task automatic test_buy_cancel();
    logic r;
    do_reset();
    drive_coin(2'b10, r); drive_coin(2'b10, r); drive_coin(2'b10, r);
    @(negedge clk); sel = 8'b0000_0100;
    @(negedge clk); sel = '0; buy = 1; cancel = 1;
    @(negedge clk); buy = 0; cancel = 0;
    checks++; if (vend_valid !== 0 || chg_valid !== 1 || err_funds !== 0) begin
      errors++; $display("FAIL buy_cancel: vv %b cv %b err %b need 0 1 0", vend_valid, chg_valid, err_funds);
    end
    make_change(300);
    run_change(1'b0);
    checks++; if (!same_seq() || chg_timeout || chg_unstable) begin errors++; $display("FAIL buy_cancel_refund: got %0d coins need %0d", got_q.size(), exp_q.size()); end
  endtask

  task automatic test_simultaneous();
    logic r;
    do_reset();
    drive_coin(2'b10, r); drive_coin(2'b10, r);
    @(negedge clk); sel = 8'b0000_0010;
    @(negedge clk); sel = '0; coin_valid = 1; coin_type = 2'b00; buy = 1;
    @(negedge clk); coin_valid = 0; buy = 0;
    checks++; if (coin_rej !== 1 || vend_valid !== 1 || credit !== 200) begin
      errors++; $display("FAIL coin_buy: rej %b vv %b credit %0d need 1 1 200", coin_rej, vend_valid, credit);
    end
    drive_coin(2'b01, r);
    checks++; if (r !== 1 || credit !== 200 || vend_valid !== 1) begin errors++; $display("FAIL coin_in_vend: rej %b credit %0d vv %b need 1 200 1", r, credit, vend_valid); end
    @(negedge clk); cancel = 1; buy = 1;
    @(negedge clk); cancel = 0; buy = 0;
    checks++; if (vend_valid !== 1 || chg_valid !== 0 || err_funds !== 0) begin errors++; $display("FAIL vend_no_abort: vv %b cv %b err %b need 1 0 0", vend_valid, chg_valid, err_funds); end
    vend_ready = 1;
    @(negedge clk); vend_ready = 0;
    checks++; if (vend_valid !== 0 || chg_valid !== 0 || credit !== 0) begin errors++; $display("FAIL exact_price: vv %b cv %b credit %0d need 0 0 0", vend_valid, chg_valid, credit); end
  endtask

  task automatic test_random();
    logic r, exp_rej;
    int mcred, n, t, k, d, held, val, rnd;
    do_reset();
    for (int it = 0; it < 25; it++) begin
      mcred = 0;
      n = $urandom_range(1, 12);
      for (int c = 0; c < n; c++) begin
        rnd = $urandom_range(0, 9);
        t = (rnd == 0) ? 3 : (rnd < 6) ? 2 : $urandom_range(0, 1);
        val = coin_cents(t);
        exp_rej = (t == 3) || (mcred + val > 1000);
        drive_coin(2'(t), r);
        checks++; if (r !== exp_rej) begin errors++; $display("FAIL rnd_coin_rej: it %0d type %0d got %b need %b", it, t, r, exp_rej); end
        if (!exp_rej) mcred += val;
      end
      checks++; if (credit !== 12'(mcred)) begin errors++; $display("FAIL rnd_credit: it %0d got %0d need %0d", it, credit, mcred); end
      k = $urandom_range(0, 7);
      @(negedge clk); sel = 8'(1 << k);
      @(negedge clk); sel = '0;
      @(negedge clk);
      checks++; if (sel_led !== 8'(1 << k)) begin errors++; $display("FAIL rnd_sel_hold: it %0d got %b need %b", it, sel_led, 8'(1 << k)); end
      buy = 1;
      @(negedge clk); buy = 0;
      if (mcred >= price_tab[k]) begin
        checks++; if (vend_valid !== 1 || vend_idx !== k[2:0] || err_funds !== 0) begin
          errors++; $display("FAIL rnd_vend: it %0d vv %b idx %0d err %b need 1 %0d 0", it, vend_valid, vend_idx, err_funds, k);
        end
        d = $urandom_range(0, 3);
        held = 0;
        for (int i = 0; i <= d; i++) begin
          if (vend_valid === 1'b1 && vend_idx === k[2:0]) held++;
          if (i == d) vend_ready = 1;
          @(negedge clk);
        end
        vend_ready = 0;
        checks++; if (held !== d + 1) begin errors++; $display("FAIL rnd_vend_hold: it %0d held %0d need %0d", it, held, d + 1); end
        make_change(mcred - price_tab[k]);
      end else begin
        checks++; if (err_funds !== 1 || vend_valid !== 0) begin errors++; $display("FAIL rnd_err: it %0d err %b vv %b need 1 0", it, err_funds, vend_valid); end
        pulse_cancel();
        make_change(mcred);
      end
      if (exp_q.size() > 0) begin
        run_change(1'b0);
        checks++; if (!same_seq() || chg_timeout || chg_unstable) begin
          errors++; $display("FAIL rnd_change: it %0d got %0d coins need %0d timeout %0d unstable %0d", it, got_q.size(), exp_q.size(), chg_timeout, chg_unstable);
        end
      end else begin
        @(negedge clk);
        checks++; if (chg_valid !== 0) begin errors++; $display("FAIL rnd_no_change: it %0d cv %b need 0", it, chg_valid); end
      end
      checks++; if (credit !== 0 || busy !== 0) begin errors++; $display("FAIL rnd_idle: it %0d credit %0d busy %b need 0 0", it, credit, busy); end
    end
  endtask

  task automatic test_reset_mid_change();
    logic r;
    do_reset();
    drive_coin(2'b10, r); drive_coin(2'b10, r);
    pulse_cancel();
    checks++; if (chg_valid !== 1) begin errors++; $display("FAIL rst_pre: cv %b need 1", chg_valid); end
    #2 rst_n = 0;
    #1;
    checks++; if (chg_valid !== 0 || credit !== 0 || busy !== 0) begin
      errors++; $display("FAIL rst_async: cv %b credit %0d busy %b need 0 0 0", chg_valid, credit, busy);
    end
    @(negedge clk); rst_n = 1;
    @(negedge clk);
  endtask

`ifdef AUTO_CANCEL_EN
  task automatic test_auto_cancel();
    logic r; int waited;
    do_reset();
    drive_coin(2'b01, r);
    waited = 0;
    while (!chg_valid && waited < 40) begin @(negedge clk); waited++; end
    checks++; if (waited < 14 || waited > 18) begin errors++; $display("FAIL auto_timing: waited %0d need 14..18", waited); end
    checks++; if (chg_valid !== 1 || chg_coin !== 2'b01) begin errors++; $display("FAIL auto_coin: cv %b coin %b need 1 01", chg_valid, chg_coin); end
    make_change(50);
    run_change(1'b1);
    checks++; if (!same_seq() || chg_timeout) begin errors++; $display("FAIL auto_refund: got %0d coins need %0d", got_q.size(), exp_q.size()); end
  endtask
`endif

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_purchase();
    test_low_funds();
    test_max_credit();
    test_cancel_refund();
    test_buy_cancel();
    test_simultaneous();
    test_random();
    test_reset_mid_change();
`ifdef AUTO_CANCEL_EN
    test_auto_cancel();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
